// File: rtl/piano_note_ctrl.sv
// Piano note controller: selects the note source by mode, latches the active note and
// gates the tone counter through IDLE/PLAY/SUSTAIN. Sustain is built only with PIANO_SUSTAIN_EN.
module piano_note_ctrl #(
    parameter int unsigned NOTE_W        = 8,
    parameter int unsigned STOP_CODE     = 99,
    parameter int unsigned SUSTAIN_TICKS = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic [NOTE_W-1:0] iPs2_Data,
    input  logic [NOTE_W-1:0] iSong_Data,
    input  logic [1:0]        iMode,
    input  logic              iTick,
    output logic [NOTE_W-1:0] oFreq_Data,
    output logic              oCountEnable,
    output logic              oNoteStart,
    output logic [1:0]        oState
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
`ifdef PIANO_SUSTAIN_EN
    localparam logic [1:0] ST_SUSTAIN = 2'd2;
`endif

    localparam logic [1:0] MODE_KEY      = 2'd0;
    localparam logic [1:0] MODE_SONG     = 2'd1;
    localparam logic [1:0] MODE_PRIORITY = 2'd2;

    localparam logic [NOTE_W-1:0] STOP_NOTE = NOTE_W'(STOP_CODE);

    function automatic logic f_valid(input logic [NOTE_W-1:0] code);
        return (code != '0) && (code != STOP_NOTE);
    endfunction

    logic [NOTE_W-1:0] w_sel;
    logic              w_sel_valid;

    always_comb begin
        w_sel = '0;
        case (iMode)
            MODE_KEY:      w_sel = iPs2_Data;
            MODE_SONG:     w_sel = iSong_Data;
            MODE_PRIORITY: w_sel = f_valid(iPs2_Data) ? iPs2_Data : iSong_Data;
            default:       w_sel = '0;
        endcase
    end

    assign w_sel_valid = f_valid(w_sel);

    logic [1:0]        r_state;
    logic [NOTE_W-1:0] r_freq;
    logic              r_en;
    logic              r_start;

`ifdef PIANO_SUSTAIN_EN
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= ST_IDLE;
            r_freq  <= '0;
            r_en    <= 1'b0;
            r_start <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_state <= ST_PLAY;
                        r_freq  <= w_sel;
                        r_en    <= 1'b1;
                        r_start <= 1'b1;
                    end else begin
                        r_freq  <= '0;
                        r_en    <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    r_en <= 1'b1;
                    if (w_sel_valid) begin
                        if (w_sel != r_freq) begin
                            r_freq  <= w_sel;
                            r_start <= 1'b1;
                        end
                    end else if (SUSTAIN_TICKS != 0) begin
                        r_state <= ST_SUSTAIN;
                        r_cnt   <= CNT_W'(SUSTAIN_TICKS);
                    end else begin
                        r_state <= ST_IDLE;
                        r_freq  <= '0;
                        r_en    <= 1'b0;
                    end
                end
                ST_SUSTAIN: begin
                    // A valid note outranks the final tick, so re-striking never passes through IDLE
                    if (w_sel_valid) begin
                        r_state <= ST_PLAY;
                        r_freq  <= w_sel;
                        r_en    <= 1'b1;
                        r_start <= 1'b1;
                        r_cnt   <= '0;
                    end else if (iTick) begin
                        if (r_cnt <= CNT_W'(1)) begin
                            r_state <= ST_IDLE;
                            r_freq  <= '0;
                            r_en    <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_freq  <= '0;
                    r_en    <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
`else
    logic             w_unused_tick;
    logic [CNT_W-1:0] w_unused_cfg;
    assign w_unused_tick = iTick;
    assign w_unused_cfg  = CNT_W'(SUSTAIN_TICKS);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= ST_IDLE;
            r_freq  <= '0;
            r_en    <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_state <= ST_PLAY;
                        r_freq  <= w_sel;
                        r_en    <= 1'b1;
                        r_start <= 1'b1;
                    end else begin
                        r_freq  <= '0;
                        r_en    <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (w_sel_valid) begin
                        r_en <= 1'b1;
                        if (w_sel != r_freq) begin
                            r_freq  <= w_sel;
                            r_start <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_freq  <= '0;
                        r_en    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_freq  <= '0;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end
`endif

    assign oFreq_Data   = r_freq;
    assign oCountEnable = r_en;
    assign oNoteStart   = r_start;
    assign oState       = r_state;

endmodule
